gpio_irq_ctrl: RTL
==================

# gpio_irq_ctrl

Pin-change interrupt controller consuming the GPIO pad inputs on the PicoBlaze port bus, beside the GPIO register block. Synchronizes the raw pad inputs and detects per-bit rising and falling edges into sticky status bits. Raises a level interrupt to the PicoBlaze that is held until `interrupt_ack` and re-armed on new events. Software reads and configures it through five port-mapped registers.

## Interface
- `GPIO_WIDTH`, 8: number of monitored pins (1..8); unused register bits read 0.
- `IRQ_BASE_ADDRESS`, 8'h10: port_id of register offset 0.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `port_id`  in  8  PicoBlaze port address.
- `data_in`  in  8  PicoBlaze write data.
- `write_strobe`  in  1  write qualifier, one cycle.
- `read_strobe`  in  1  read qualifier (unused for decode; reads have no side effects).
- `data_out`  out  8  registered read data; 0 when port_id is not in this block's range, so it can be OR-ed with other peripherals.
- `gpio_data_in`  in  GPIO_WIDTH  raw pad inputs, asynchronous to clk.
- `interrupt`  out  1  level interrupt to PicoBlaze.
- `interrupt_ack`  in  1  PicoBlaze acknowledge pulse.

## Operation
- Registers (offset from IRQ_BASE_ADDRESS; reset 0):
  - +0 SYNC_IN: RO, synchronized pin value.
  - +1 MASK: RW.
  - +2 RISE_EN: RW.
  - +3 FALL_EN: RW.
  - +4 STATUS: R/W1C, pending edges.
  - +5..+7 read 0 and ignore writes.
- Synchronizer: two flops per pin (`s1`, `s2`). `prev` holds the last `s2`.
- Edge detection:
  - `rise = s2 & ~prev & RISE_EN`, `fall = ~s2 & prev & FALL_EN`.
  - `set = rise | fall`. STATUS |= set. MASK does not gate STATUS.
- Priming: a 2-bit counter after reset suppresses `set` until `s1`, `s2` and `prev` all hold real pad data (3 cycles). A pin that is high at reset release gives no rising event.
- W1C: a write to +4 clears the bits written as 1. If `set` and clear hit the same bit in the same cycle, set wins.
- `irq_req = |(STATUS & MASK)`.
- Interrupt FSM:
  - IDLE (interrupt=0): irq_req → ASSERT.
  - ASSERT (interrupt=1): interrupt_ack → WAIT. Otherwise stay, even if irq_req drops (no retraction once raised).
  - WAIT (interrupt=0): any `set & MASK` bit → ASSERT. irq_req=0 → IDLE. Otherwise stay.
  - interrupt_ack outside ASSERT is ignored.
- Reset mid-operation clears all registers, STATUS, the FSM (→IDLE) and the priming counter in the cycle reset is sampled.

## Timing
- Reset values: data_out=0, interrupt=0, all registers 0, FSM=IDLE.
- Pad change sampled into `s1` at edge k:
  - `s2` updates at k+1.
  - STATUS bit sets at k+2.
  - interrupt rises at k+3 (if masked in and FSM in IDLE).
- Read latency: data_out reflects `port_id` sampled at edge k, valid after edge k (one register stage). This matches PicoBlaze INPUT timing when port_id is stable for 2 cycles.
- Register writes take effect at the edge where write_strobe is sampled. A MASK write affects irq_req the following cycle.
- interrupt falls the cycle after interrupt_ack is sampled in ASSERT.

## Structure
- Package `gpio_irq_pkg`:
  - register offset constants (`IRQ_SYNC_IN`..`IRQ_STATUS`)
  - FSM state enum (`IRQ_IDLE`, `IRQ_ASSERT`, `IRQ_WAIT`)
  - priming count constant (3)
- Sub-module `gpio_sync`: parameterized-width two-flop synchronizer with synchronous reset to 0. It is reused by later pad-input blocks.
- Top holds the edge logic, registers, read mux and FSM.

## Test plan
- Reset with pin0 held high, RISE_EN=8'h01 written after reset → STATUS reads 8'h00. A later 1→0→1 on pin0 → STATUS=8'h01.
- MASK=8'h04, FALL_EN=8'h04, pin2 1→0 at edge k → STATUS=8'h04 at k+2, interrupt=1 at k+3. Pulse interrupt_ack → interrupt=0 next cycle, FSM WAIT.
- In WAIT with STATUS bit2 still set, a second falling edge on pin2 → interrupt reasserts. Write 8'h04 to +4 after ack → FSM IDLE, interrupt stays 0.
- Rising edge on pin5 in the same cycle as a W1C write of 8'h20 → STATUS bit5 remains 1.
- Read +0 with pins=8'hA5 after 3 cycles → data_out=8'hA5. Read port_id outside the block's range → data_out=8'h00. Write +6 → no register changes.
- Assert reset while interrupt=1 and STATUS=8'hFF → next cycle interrupt=0, STATUS=0, MASK=0, and no edge events during the 3 priming cycles.

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// Shared constants and types for the GPIO pin-change interrupt controller.
package gpio_irq_pkg;

    // Register offsets relative to IRQ_BASE_ADDRESS
    localparam logic [2:0] IRQ_SYNC_IN = 3'd0;
    localparam logic [2:0] IRQ_MASK    = 3'd1;
    localparam logic [2:0] IRQ_RISE_EN = 3'd2;
    localparam logic [2:0] IRQ_FALL_EN = 3'd3;
    localparam logic [2:0] IRQ_STATUS  = 3'd4;

    // Cycles after reset before s1, s2 and prev all carry real pad data
    localparam logic [1:0] IRQ_PRIME_COUNT = 2'd3;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_ASSERT = 2'd1,
        IRQ_WAIT   = 2'd2
    } irq_state_t;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous pad inputs, synchronous reset to 0.
module gpio_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] sync
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // Two-stage capture of the pad value into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pad;
            s2 <= s1;
        end
    end

    assign sync = s2;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Pin-change interrupt controller: edge detection into sticky status,
// port-mapped registers and a level interrupt held until acknowledged.
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH       = 8,
    parameter logic [7:0]  IRQ_BASE_ADDRESS = 8'h10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            port_id,
    input  logic [7:0]            data_in,
    input  logic                  write_strobe,
    input  logic                  read_strobe,
    output logic [7:0]            data_out,
    input  logic [GPIO_WIDTH-1:0] gpio_data_in,
    output logic                  interrupt,
    input  logic                  interrupt_ack
);

    logic [GPIO_WIDTH-1:0] s2;
    logic [GPIO_WIDTH-1:0] prev;
    logic [GPIO_WIDTH-1:0] mask;
    logic [GPIO_WIDTH-1:0] rise_en;
    logic [GPIO_WIDTH-1:0] fall_en;
    logic [GPIO_WIDTH-1:0] status;
    logic [GPIO_WIDTH-1:0] set;
    logic [GPIO_WIDTH-1:0] clr;
    logic [1:0]            prime_cnt;
    logic                  primed;
    logic [7:0]            offset;
    logic [2:0]            reg_sel;
    logic                  in_range;
    logic                  wr_en;
    logic                  irq_req;
    logic [7:0]            rd_word;
    irq_state_t            state;
    irq_state_t            state_next;
    logic                  unused;

    // Reads have no side effects, so the read qualifier carries no information
    assign unused = read_strobe ^ (^data_in);

    gpio_sync #(
        .WIDTH (GPIO_WIDTH)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .pad   (gpio_data_in),
        .sync  (s2)
    );

    assign offset   = port_id - IRQ_BASE_ADDRESS;
    assign in_range = (offset[7:3] == 5'd0);
    assign reg_sel  = offset[2:0];
    assign wr_en    = write_strobe && in_range;

    // Edge detection, W1C clear vector and interrupt request
    always_comb begin
        primed  = (prime_cnt == IRQ_PRIME_COUNT);
        set     = '0;
        clr     = '0;
        if (primed) begin
            set = (s2 & ~prev & rise_en) | (~s2 & prev & fall_en);
        end
        if (wr_en && reg_sel == IRQ_STATUS) begin
            clr = data_in[GPIO_WIDTH-1:0];
        end
        irq_req = |(status & mask);
    end

    // Edge history, priming counter, configuration and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            prev      <= '0;
            prime_cnt <= '0;
            mask      <= '0;
            rise_en   <= '0;
            fall_en   <= '0;
            status    <= '0;
        end else begin
            prev <= s2;
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
            // Set is applied after clear so a same-cycle event survives W1C
            status <= (status & ~clr) | set;
            if (wr_en) begin
                case (reg_sel)
                    IRQ_MASK:    mask    <= data_in[GPIO_WIDTH-1:0];
                    IRQ_RISE_EN: rise_en <= data_in[GPIO_WIDTH-1:0];
                    IRQ_FALL_EN: fall_en <= data_in[GPIO_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Read mux; unused offsets and unused upper bits read as 0
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            IRQ_SYNC_IN: rd_word[GPIO_WIDTH-1:0] = s2;
            IRQ_MASK:    rd_word[GPIO_WIDTH-1:0] = mask;
            IRQ_RISE_EN: rd_word[GPIO_WIDTH-1:0] = rise_en;
            IRQ_FALL_EN: rd_word[GPIO_WIDTH-1:0] = fall_en;
            IRQ_STATUS:  rd_word[GPIO_WIDTH-1:0] = status;
            default: ;
        endcase
    end

    // Registered read data, zero outside this block's address window
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= in_range ? rd_word : 8'h00;
        end
    end

    // Interrupt FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IRQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Interrupt FSM next state and output
    always_comb begin
        state_next = state;
        interrupt  = 1'b0;
        case (state)
            IRQ_IDLE: begin
                if (irq_req) begin
                    state_next = IRQ_ASSERT;
                end
            end
            IRQ_ASSERT: begin
                interrupt = 1'b1;
                if (interrupt_ack) begin
                    state_next = IRQ_WAIT;
                end
            end
            IRQ_WAIT: begin
                if (|(set & mask)) begin
                    state_next = IRQ_ASSERT;
                end else if (!irq_req) begin
                    state_next = IRQ_IDLE;
                end
            end
            default: state_next = IRQ_IDLE;
        endcase
    end

endmodule
